// File: rtl/img_row_writer.sv
// Packs a raster pixel stream into an IMG_H x IMG_W frame buffer and serves K-row windows to im2col.
// Ports: i_clk, i_rst (async active-low), pixel valid/ready/data in, frame valid/done handshake, K-row read port, row status.
module img_row_writer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int AW    = 5
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_pix_valid,
  output logic                              o_pix_ready,
  input  logic [DW-1:0]                     i_pix,
  output logic                              o_frame_valid,
  input  logic                              i_frame_done,
  input  logic [AW-1:0]                     i_addr,
  output logic [K-1:0][IMG_W-1:0][DW-1:0]   o_data,
  output logic [$clog2(IMG_H+1)-1:0]        o_row_cnt
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NW = $clog2(IMG_H+1);

  typedef enum logic {FILL, READY} state_t;

  state_t                          state;
  logic [CW-1:0]                   col;
  logic [RW-1:0]                   row;
  logic [IMG_H-1:0][IMG_W-1:0][DW-1:0] mem;

  logic accept;
  assign accept = i_pix_valid & o_pix_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= FILL;
      col           <= '0;
      row           <= '0;
      o_row_cnt     <= '0;
      o_pix_ready   <= 1'b1;
      o_frame_valid <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            if (col == CW'(IMG_W-1)) begin
              col       <= '0;
              o_row_cnt <= o_row_cnt + NW'(1);
              if (row == RW'(IMG_H-1)) begin
                row           <= '0;
                state         <= READY;
                o_pix_ready   <= 1'b0;
                o_frame_valid <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        READY: begin
          if (i_frame_done) begin
            state         <= FILL;
            o_row_cnt     <= '0;
            o_pix_ready   <= 1'b1;
            o_frame_valid <= 1'b0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  // Pixel storage carries no reset; contents persist until overwritten.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[row][col] <= i_pix;
    end
  end

  // Windows past the last valid top row read as zero; row index is
  // forced to 0 there so no out-of-range index is ever formed.
  logic                   rd_ok;
  logic [K-1:0][RW-1:0]   rd_row;

  assign rd_ok = (32'(i_addr) <= 32'(IMG_H-K));

  always_comb begin
    rd_row = '0;
    for (int k = 0; k < K; k++) begin
      if (rd_ok) begin
        rd_row[k] = RW'(32'(i_addr) + 32'(k));
      end
    end
  end

  always_comb begin
    o_data = '0;
    for (int k = 0; k < K; k++) begin
      if (rd_ok) begin
        o_data[k] = mem[rd_row[k]];
      end
    end
  end

endmodule

// File: tb/tb_img_row_writer.sv
// Self-checking bench for img_row_writer.
// Directed read-vector table plus hand sequences for fill, gaps, READY hold, release and async reset.
module tb_img_row_writer;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int NPIX  = IMG_W*IMG_H;

  logic                             i_clk;
  logic                             i_rst;
  logic                             i_pix_valid;
  logic                             o_pix_ready;
  logic [DW-1:0]                    i_pix;
  logic                             o_frame_valid;
  logic                             i_frame_done;
  logic [AW-1:0]                    i_addr;
  logic [K-1:0][IMG_W-1:0][DW-1:0]  o_data;
  logic [4:0]                       o_row_cnt;

  img_row_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .AW(AW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .i_pix        (i_pix),
    .o_frame_valid(o_frame_valid),
    .i_frame_done (i_frame_done),
    .i_addr       (i_addr),
    .o_data       (o_data),
    .o_row_cnt    (o_row_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            k;
    int            c;
    int            exp;
  } rd_vec_t;

  rd_vec_t tv [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixv(input bit a5, input int idx);
    if (a5) return 8'hA5;
    return 8'(idx % 256);
  endfunction

  task automatic fill(input bit a5, input bit gaps,
                      input int from, input int upto);
    int idx;
    int budget;
    idx = from;
    budget = 0;
    while (idx < upto && budget < 20000) begin
      i_pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_pix = pixv(a5, idx);
      @(posedge i_clk);
      #1;
      budget++;
      if (i_pix_valid) idx++;
      chk("row_cnt", 32'(o_row_cnt), (idx == NPIX) ? IMG_H : idx / IMG_W);
      chk("frame_valid", 32'(o_frame_valid), 32'(idx == NPIX));
      chk("pix_ready", 32'(o_pix_ready), 32'(idx != NPIX));
    end
    i_pix_valid = 1'b0;
    if (idx < upto) chk("fill_timeout", idx, upto);
  endtask

  task automatic run_table();
    for (int i = 0; i < 10; i++) begin
      i_addr = tv[i].addr;
      #1;
      chk($sformatf("rd_a%0d_k%0d_c%0d", tv[i].addr, tv[i].k, tv[i].c),
          32'(o_data[tv[i].k][tv[i].c]), tv[i].exp);
    end
  endtask

  task automatic check_buf(input bit a5);
    for (int a = 0; a <= IMG_H-K; a++) begin
      i_addr = AW'(a);
      #1;
      for (int k = 0; k < K; k++)
        for (int c = 0; c < IMG_W; c++)
          chk($sformatf("buf_a%0d_k%0d_c%0d", a, k, c),
              32'(o_data[k][c]), 32'(pixv(a5, (a+k)*IMG_W + c)));
    end
  endtask

  task automatic check_zero(input logic [AW-1:0] a);
    i_addr = a;
    #1;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < IMG_W; c++)
        chk($sformatf("zero_a%0d_k%0d_c%0d", a, k, c),
            32'(o_data[k][c]), 0);
  endtask

  task automatic release_frame();
    i_frame_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_frame_done = 1'b0;
    chk("rel_frame_valid", 32'(o_frame_valid), 0);
    chk("rel_pix_ready", 32'(o_pix_ready), 1);
    chk("rel_row_cnt", 32'(o_row_cnt), 0);
  endtask

  initial begin
    tv[0] = '{addr: 5'd0,  k: 0, c: 5,  exp: 5};
    tv[1] = '{addr: 5'd0,  k: 2, c: 27, exp: 83};
    tv[2] = '{addr: 5'd25, k: 0, c: 0,  exp: 188};
    tv[3] = '{addr: 5'd25, k: 2, c: 27, exp: 15};
    tv[4] = '{addr: 5'd10, k: 1, c: 3,  exp: 55};
    tv[5] = '{addr: 5'd1,  k: 0, c: 0,  exp: 28};
    tv[6] = '{addr: 5'd9,  k: 2, c: 0,  exp: 52};
    tv[7] = '{addr: 5'd26, k: 0, c: 0,  exp: 0};
    tv[8] = '{addr: 5'd31, k: 2, c: 27, exp: 0};
    tv[9] = '{addr: 5'd27, k: 1, c: 10, exp: 0};

    i_rst = 1'b0;
    i_pix_valid = 1'b0;
    i_pix = '0;
    i_frame_done = 1'b0;
    i_addr = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_frame_valid", 32'(o_frame_valid), 0);
    chk("rst_pix_ready", 32'(o_pix_ready), 1);
    chk("rst_row_cnt", 32'(o_row_cnt), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;

    fill(1'b0, 1'b0, 0, NPIX);
    run_table();
    check_zero(5'd26);
    check_zero(5'd31);

    i_pix_valid = 1'b1;
    i_pix = 8'hFF;
    repeat (50) @(posedge i_clk);
    #1;
    i_pix_valid = 1'b0;
    chk("hold_row_cnt", 32'(o_row_cnt), 28);
    chk("hold_frame_valid", 32'(o_frame_valid), 1);
    chk("hold_pix_ready", 32'(o_pix_ready), 0);
    run_table();

    release_frame();
    fill(1'b0, 1'b1, 0, NPIX);
    check_buf(1'b0);

    release_frame();
    fill(1'b1, 1'b0, 0, NPIX);
    check_buf(1'b1);
    check_zero(5'd26);

    release_frame();
    fill(1'b0, 1'b0, 0, 100);
    #2;
    i_rst = 1'b0;
    #1;
    chk("arst_row_cnt", 32'(o_row_cnt), 0);
    chk("arst_frame_valid", 32'(o_frame_valid), 0);
    chk("arst_pix_ready", 32'(o_pix_ready), 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;

    fill(1'b0, 1'b0, 0, 50);
    i_frame_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_frame_done = 1'b0;
    chk("fill_done_row_cnt", 32'(o_row_cnt), 1);
    chk("fill_done_pix_ready", 32'(o_pix_ready), 1);
    fill(1'b0, 1'b0, 50, NPIX);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
